// File: rtl/key_loader_pkg.sv
// Shared types and sizing for the serial key loader.
// KEY_PARITY_EN adds one odd-parity bit after every key slice on the wire.
package key_loader_pkg;

    localparam int KEY_WIDTH   = 64;
    localparam int SLICE_WIDTH = 8;
    localparam int MAX_TRIES   = 3;
    localparam int NUM_SLICES  = KEY_WIDTH / SLICE_WIDTH;

`ifdef KEY_PARITY_EN
    localparam int FRAME_BITS = KEY_WIDTH + NUM_SLICES;
`else
    localparam int FRAME_BITS = KEY_WIDTH;
`endif

    localparam int CNT_W  = $clog2(FRAME_BITS);
    localparam int FAIL_W = 3;

    typedef enum logic [2:0] {
        KL_IDLE,
        KL_SHIFT,
        KL_CHECK,
        KL_LOADED,
        KL_ERROR,
        KL_DEAD
    } kl_state_t;

endpackage

// File: rtl/key_loader_if.sv
// Key source <-> key loader signals, plus FSM state and failure count for observation.
// key_start is a single-cycle pulse; key_bit is sampled only on cycles where key_bit_valid is high.
interface key_loader_if import key_loader_pkg::*;;

    logic                  key_start;
    logic                  key_bit_valid;
    logic                  key_bit;
    logic [KEY_WIDTH-1:0]  key_out;
    logic                  key_valid;
    logic                  key_err;
    logic                  key_dead;
    logic                  busy;
    logic                  cpu_hold;
    kl_state_t             state_dbg;
    logic [FAIL_W-1:0]     fail_cnt_dbg;

    modport master (
        output key_start, key_bit_valid, key_bit,
        input  key_out, key_valid, key_err, key_dead, busy, cpu_hold,
        input  state_dbg, fail_cnt_dbg
    );

    modport slave (
        input  key_start, key_bit_valid, key_bit,
        output key_out, key_valid, key_err, key_dead, busy, cpu_hold,
        output state_dbg, fail_cnt_dbg
    );

endinterface

// File: rtl/key_parity_check.sv
// Per-slice odd-parity tracker for the serial key stream; flags a parity bit on the wire
// and latches a sticky failure when any slice plus its parity bit has even weight.
module key_parity_check import key_loader_pkg::*; #(
    parameter int SLICE_WIDTH_P = SLICE_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_bit_en,
    input  logic i_bit,
    output logic o_is_parity,
    output logic o_parity_fail
);

    localparam int POS_W = $clog2(SLICE_WIDTH_P + 1);

    logic [POS_W-1:0] r_pos;
    logic             r_acc;
    logic             r_fail;

    assign o_is_parity   = (r_pos == POS_W'(SLICE_WIDTH_P));
    assign o_parity_fail = r_fail;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_pos  <= '0;
            r_acc  <= 1'b0;
            r_fail <= 1'b0;
        end else if (i_bit_en) begin
            if (o_is_parity) begin
                // Odd parity: data weight XOR parity bit must be 1.
                if (!(r_acc ^ i_bit)) begin
                    r_fail <= 1'b1;
                end
                r_pos <= '0;
                r_acc <= 1'b0;
            end else begin
                r_acc <= r_acc ^ i_bit;
                r_pos <= r_pos + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_loader.sv
// Serial key loader: shifts the unlock key in MSB first, commits it once, and holds the core until then.
// Optional build macro: KEY_PARITY_EN (per-slice odd parity with lockout after MAX_TRIES failures).
module key_loader import key_loader_pkg::*; (
    input logic          clk,
    input logic          rst,
    key_loader_if.slave  bus
);

    kl_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [KEY_WIDTH-1:0] r_shadow;
    logic [KEY_WIDTH-1:0] r_key_out;
    logic                 r_key_valid;
    logic                 r_busy;

    logic w_frame_start;
    logic w_bit_take;
    logic w_is_parity;

    assign w_frame_start = bus.key_start &&
                           (r_state == KL_IDLE || r_state == KL_SHIFT || r_state == KL_ERROR);
    assign w_bit_take    = (r_state == KL_SHIFT) && !bus.key_start && bus.key_bit_valid;

`ifdef KEY_PARITY_EN
    logic              w_parity_fail;
    logic              r_key_err;
    logic              r_key_dead;
    logic [FAIL_W-1:0] r_fail_cnt;

    key_parity_check #(.SLICE_WIDTH_P(SLICE_WIDTH)) u_parity (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_frame_start),
        .i_bit_en      (w_bit_take),
        .i_bit         (bus.key_bit),
        .o_is_parity   (w_is_parity),
        .o_parity_fail (w_parity_fail)
    );

    assign bus.key_err      = r_key_err;
    assign bus.key_dead     = r_key_dead;
    assign bus.fail_cnt_dbg = r_fail_cnt;
`else
    assign w_is_parity      = 1'b0;
    assign bus.key_err      = 1'b0;
    assign bus.key_dead     = 1'b0;
    assign bus.fail_cnt_dbg = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= KL_IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef KEY_PARITY_EN
            r_key_err   <= 1'b0;
            r_key_dead  <= 1'b0;
            r_fail_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                KL_IDLE: begin
                    if (w_frame_start) begin
                        r_state  <= KL_SHIFT;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                KL_SHIFT: begin
                    if (w_frame_start) begin
                        r_cnt    <= '0;
                        r_shadow <= '0;
                    end else if (w_bit_take) begin
                        // Parity bits advance the frame count but never reach the shadow.
                        if (!w_is_parity) begin
                            r_shadow <= {r_shadow[KEY_WIDTH-2:0], bus.key_bit};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            r_state <= KL_CHECK;
                        end
                    end
                end
                KL_CHECK: begin
                    r_busy <= 1'b0;
`ifdef KEY_PARITY_EN
                    if (w_parity_fail) begin
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                        if (r_fail_cnt + 1'b1 == FAIL_W'(MAX_TRIES)) begin
                            r_key_dead <= 1'b1;
                            r_state    <= KL_DEAD;
                        end else begin
                            r_key_err <= 1'b1;
                            r_state   <= KL_ERROR;
                        end
                    end else
`endif
                    begin
                        r_key_out   <= r_shadow;
                        r_key_valid <= 1'b1;
                        r_state     <= KL_LOADED;
                    end
                end
`ifdef KEY_PARITY_EN
                KL_ERROR: begin
                    if (w_frame_start) begin
                        r_key_err <= 1'b0;
                        r_state   <= KL_SHIFT;
                        r_cnt     <= '0;
                        r_shadow  <= '0;
                        r_busy    <= 1'b1;
                    end
                end
`endif
                KL_LOADED, KL_DEAD: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= KL_IDLE;
                end
            endcase
        end
    end

    assign bus.key_out   = r_key_out;
    assign bus.key_valid = r_key_valid;
    assign bus.busy      = r_busy;
    assign bus.cpu_hold  = ~r_key_valid;
    assign bus.state_dbg = r_state;

endmodule
